// File: rtl/sram_writer.sv
// sram_writer
//   Takes one 32-bit sample per sram_start pulse, requests the shared SRAM port
//   from an arbiter, writes the sample into a circular buffer, then pulses
//   data_done back to the upstream stage.
//
// Ports
//   wb_clk         in   clock, rising edge
//   wb_rst         in   asynchronous active-high reset
//   sram_start     in   one-cycle start pulse, sram_data_in valid alongside it
//   sram_data_in   in   32-bit sample to store
//   grant          in   arbiter grant (level)
//   base_addr      in   AW-bit first word of the circular buffer
//   buffer_length  in   AW-bit buffer size in words, 0 = 2^AW
//   request        out  SRAM port request to the arbiter
//   sram_ce        out  SRAM chip enable
//   sram_we        out  SRAM write enable
//   sram_addr      out  AW-bit SRAM word address
//   sram_wdata     out  32-bit SRAM write data
//   data_done      out  one-cycle pulse after the write
//   wrap           out  pulse during the write of the last buffer word
//   busy           out  high whenever not idle
//   overrun        out  sticky: a start arrived while busy

module sram_writer #(
  parameter int AW = 10
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          sram_start,
  input  logic [31:0]   sram_data_in,
  input  logic          grant,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] buffer_length,
  output logic          request,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  output logic          data_done,
  output logic          wrap,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ZERO = {AW{1'b0}};

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] offset_r;
  logic [31:0]   hold_r;
  logic          overrun_r;

  // Registered copies of every output, loaded from the decode of the next state
  logic          request_r;
  logic          ce_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wdata_r;
  logic          done_r;
  logic          wrap_r;
  logic          busy_r;

  logic          request_nxt_s;
  logic          ce_nxt_s;
  logic          we_nxt_s;
  logic [AW-1:0] addr_nxt_s;
  logic [31:0]   wdata_nxt_s;
  logic          done_nxt_s;
  logic          wrap_nxt_s;
  logic          busy_nxt_s;

  logic [AW-1:0] last_idx_s;
  logic          last_s;

  // Index of the last buffer word; buffer_length=0 wraps to all-ones = 2^AW-1
  assign last_idx_s = buffer_length - ONE;
  assign last_s     = (offset_r == last_idx_s);

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sram_start) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (grant) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WRITE:   state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode of the state being entered, so the registered outputs
  // line up with the state register cycle for cycle
  always_comb begin
    request_nxt_s = 1'b0;
    ce_nxt_s      = 1'b0;
    we_nxt_s      = 1'b0;
    addr_nxt_s    = ZERO;
    wdata_nxt_s   = 32'd0;
    done_nxt_s    = 1'b0;
    wrap_nxt_s    = 1'b0;
    busy_nxt_s    = 1'b1;
    case (state_nxt_s)
      IDLE: begin
        busy_nxt_s = 1'b0;
      end
      REQ: begin
        request_nxt_s = 1'b1;
      end
      WRITE: begin
        // offset_r and hold_r are stable throughout REQ, so they are
        // valid for the WRITE cycle being entered
        request_nxt_s = 1'b1;
        ce_nxt_s      = 1'b1;
        we_nxt_s      = 1'b1;
        addr_nxt_s    = base_addr + offset_r;
        wdata_nxt_s   = hold_r;
        wrap_nxt_s    = last_s;
      end
      DONE: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Hold register: captures the sample only when a start is accepted in IDLE
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      hold_r <= 32'd0;
    end else if ((state_r == IDLE) && sram_start) begin
      hold_r <= sram_data_in;
    end
  end

  // Circular-buffer offset, advanced as the WRITE cycle ends
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      offset_r <= ZERO;
    end else if (state_r == WRITE) begin
      if (last_s) begin
        offset_r <= ZERO;
      end else begin
        offset_r <= offset_r + ONE;
      end
    end
  end

  // Sticky overrun: any start outside IDLE (including DONE) is dropped and flagged
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      overrun_r <= 1'b0;
    end else if ((state_r != IDLE) && sram_start) begin
      overrun_r <= 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      request_r <= 1'b0;
      ce_r      <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= ZERO;
      wdata_r   <= 32'd0;
      done_r    <= 1'b0;
      wrap_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      request_r <= request_nxt_s;
      ce_r      <= ce_nxt_s;
      we_r      <= we_nxt_s;
      addr_r    <= addr_nxt_s;
      wdata_r   <= wdata_nxt_s;
      done_r    <= done_nxt_s;
      wrap_r    <= wrap_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign request    = request_r;
  assign sram_ce    = ce_r;
  assign sram_we    = we_r;
  assign sram_addr  = addr_r;
  assign sram_wdata = wdata_r;
  assign data_done  = done_r;
  assign wrap       = wrap_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_sram_writer.sv
// tb_sram_writer
//   Self-checking bench for sram_writer: table of single writes with
//   expected address/wrap, hand sequences for reset, grant stall, overrun
//   and abort, and randomized write streams against an arithmetic model
//   (address = base + (n mod length) mod 2^AW).

module tb_sram_writer;

  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          wb_clk;
  logic          wb_rst;
  logic          sram_start;
  logic [31:0]   sram_data_in;
  logic          grant;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] buffer_length;
  logic          request;
  logic          sram_ce;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic          data_done;
  logic          wrap;
  logic          busy;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  sram_writer #(.AW(AW)) dut (
    .wb_clk        (wb_clk),
    .wb_rst        (wb_rst),
    .sram_start    (sram_start),
    .sram_data_in  (sram_data_in),
    .grant         (grant),
    .base_addr     (base_addr),
    .buffer_length (buffer_length),
    .request       (request),
    .sram_ce       (sram_ce),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .data_done     (data_done),
    .wrap          (wrap),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  typedef struct {
    bit          rst_before;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic [31:0] data;
    int          gdelay;
    logic [AW-1:0] exp_addr;
    bit          exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_request"}, 32'(request),   32'd0);
    check({tag, "_ce"},      32'(sram_ce),   32'd0);
    check({tag, "_we"},      32'(sram_we),   32'd0);
    check({tag, "_addr"},    32'(sram_addr), 32'd0);
    check({tag, "_wdata"},   sram_wdata,     32'd0);
    check({tag, "_done"},    32'(data_done), 32'd0);
    check({tag, "_wrap"},    32'(wrap),      32'd0);
    check({tag, "_busy"},    32'(busy),      32'd0);
    check({tag, "_overrun"}, 32'(overrun),   32'd0);
  endtask

  task automatic do_reset();
    @(posedge wb_clk);
    #1;
    sram_start = 1'b0;
    wb_rst = 1'b1;
    #3;
    wb_rst = 1'b0;
  endtask

  // One complete transfer: start, optional grant stall, WRITE, DONE, IDLE
  task automatic do_write(input logic [31:0] data, input int gdelay,
                          input logic [AW-1:0] exp_addr, input bit exp_wrap);
    sram_start   = 1'b1;
    sram_data_in = data;
    grant        = (gdelay == 0);
    tick();
    sram_start   = 1'b0;
    sram_data_in = 32'h0;
    check("req_request", 32'(request), 32'd1);
    check("req_we",      32'(sram_we), 32'd0);
    check("req_busy",    32'(busy),    32'd1);
    for (int i = 0; i < gdelay; i++) begin
      tick();
      check("stall_request", 32'(request), 32'd1);
      check("stall_we",      32'(sram_we), 32'd0);
    end
    grant = 1'b1;
    if (gdelay != 0) tick();
    else tick();
    check("wr_we",      32'(sram_we),   32'd1);
    check("wr_ce",      32'(sram_ce),   32'd1);
    check("wr_request", 32'(request),   32'd1);
    check("wr_addr",    32'(sram_addr), 32'(exp_addr));
    check("wr_wdata",   sram_wdata,     data);
    check("wr_wrap",    32'(wrap),      32'(exp_wrap));
    check("wr_done",    32'(data_done), 32'd0);
    grant = 1'b0;  // deasserting grant during WRITE must not stop the write
    tick();
    check("dn_done",    32'(data_done), 32'd1);
    check("dn_we",      32'(sram_we),   32'd0);
    check("dn_addr",    32'(sram_addr), 32'd0);
    check("dn_wdata",   sram_wdata,     32'd0);
    check("dn_request", 32'(request),   32'd0);
    check("dn_wrap",    32'(wrap),      32'd0);
    tick();
    check("idle_done",  32'(data_done), 32'd0);
    check("idle_busy",  32'(busy),      32'd0);
  endtask

  function automatic vec_t mk(input bit r, input int b, input int l, input int e, input bit w);
    vec_t v;
    v.rst_before = r;
    v.base       = AW'(b);
    v.len        = AW'(l);
    v.data       = $urandom;
    v.gdelay     = int'($urandom_range(0, 2));
    v.exp_addr   = AW'(e);
    v.exp_wrap   = w;
    return v;
  endfunction

  initial begin
    int            len_i;
    int            nw;
    int            off;
    logic [AW-1:0] ea;
    logic [31:0]   da;

    wb_rst = 1'b1; sram_start = 1'b0; sram_data_in = 32'h0; grant = 1'b0;
    base_addr = '0; buffer_length = '0;

    // Reset state, both while asserted and after release
    #12;
    check_all_zero("in_reset");
    sram_start = 1'b1; sram_data_in = 32'hFFFF_FFFF; grant = 1'b1;
    tick();
    check_all_zero("held_reset");
    sram_start = 1'b0; grant = 1'b0;
    wb_rst = 1'b0;
    tick();
    check_all_zero("released");

    // Basic write with immediate grant
    base_addr = 10'h100; buffer_length = 10'd0;
    do_write(32'hDEAD_BEEF, 0, 10'h100, 1'b0);
    // Grant stalled 10 cycles
    do_write(32'h1234_5678, 10, 10'h101, 1'b0);

    // Table: circular-buffer addressing and wrap
    vecs.push_back(mk(1, 'h10, 4, 'h10, 0));
    vecs.push_back(mk(0, 'h10, 4, 'h11, 0));
    vecs.push_back(mk(0, 'h10, 4, 'h12, 0));
    vecs.push_back(mk(0, 'h10, 4, 'h13, 1));
    vecs.push_back(mk(0, 'h10, 4, 'h10, 0));
    vecs.push_back(mk(1, 'h3FE, 4, 'h3FE, 0));
    vecs.push_back(mk(0, 'h3FE, 4, 'h3FF, 0));
    vecs.push_back(mk(0, 'h3FE, 4, 'h000, 0));
    vecs.push_back(mk(0, 'h3FE, 4, 'h001, 1));
    vecs.push_back(mk(0, 'h3FE, 4, 'h3FE, 0));
    vecs.push_back(mk(1, 'h55, 1, 'h55, 1));
    vecs.push_back(mk(0, 'h55, 1, 'h55, 1));
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      base_addr     = vecs[i].base;
      buffer_length = vecs[i].len;
      do_write(vecs[i].data, vecs[i].gdelay, vecs[i].exp_addr, vecs[i].exp_wrap);
    end

    // Second start while in REQ: overrun set, first data written
    do_reset();
    base_addr = 10'h200; buffer_length = 10'd0;
    check("ovr_clear", 32'(overrun), 32'd0);
    sram_start = 1'b1; sram_data_in = 32'hAAAA_0001; grant = 1'b0;
    tick();
    check("ovr_before", 32'(overrun), 32'd0);
    sram_start = 1'b1; sram_data_in = 32'hBBBB_0002;
    tick();
    sram_start = 1'b0; sram_data_in = 32'h0;
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_request", 32'(request), 32'd1);
    grant = 1'b1;
    tick();
    check("ovr_wdata", sram_wdata, 32'hAAAA_0001);
    check("ovr_addr", 32'(sram_addr), 32'h200);
    grant = 1'b0;
    tick(); tick(); tick();
    check("ovr_sticky", 32'(overrun), 32'd1);
    do_write(32'hCCCC_0003, 0, 10'h201, 1'b0);
    check("ovr_sticky2", 32'(overrun), 32'd1);
    do_reset();
    check("ovr_rst", 32'(overrun), 32'd0);

    // Start in the DONE cycle counts as overrun and is not accepted
    sram_start = 1'b1; sram_data_in = 32'h0F0F_0F0F; grant = 1'b1;
    tick();
    sram_start = 1'b0;
    tick();
    check("dov_we", 32'(sram_we), 32'd1);
    tick();
    check("dov_done", 32'(data_done), 32'd1);
    sram_start = 1'b1; sram_data_in = 32'h5555_5555;
    tick();
    sram_start = 1'b0;
    check("dov_overrun", 32'(overrun), 32'd1);
    check("dov_busy", 32'(busy), 32'd0);
    tick();
    check("dov_notaken", 32'(request), 32'd0);
    grant = 1'b0;

    // Reset during REQ aborts; next write restarts at base
    do_reset();
    base_addr = 10'h040; buffer_length = 10'd8;
    do_write(32'h1111_1111, 1, 10'h040, 1'b0);
    do_write(32'h2222_2222, 0, 10'h041, 1'b0);
    sram_start = 1'b1; sram_data_in = 32'h3333_3333; grant = 1'b0;
    tick();
    sram_start = 1'b0;
    check("abort_req", 32'(request), 32'd1);
    wb_rst = 1'b1;
    #1;
    check("abort_req_drop", 32'(request), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    #2;
    wb_rst = 1'b0;
    grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_done", 32'(data_done), 32'd0);
      check("abort_no_we", 32'(sram_we), 32'd0);
    end
    do_write(32'h4444_4444, 0, 10'h040, 1'b0);

    // Randomized streams against the arithmetic model
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      base_addr = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 4) == 0) buffer_length = '0;
      else buffer_length = AW'($urandom_range(1, 6));
      len_i = (buffer_length == '0) ? DEPTH : int'(buffer_length);
      nw = int'($urandom_range(3, 14));
      for (int n = 0; n < nw; n++) begin
        off = n % len_i;
        ea  = AW'((int'(base_addr) + off) % DEPTH);
        da  = $urandom;
        do_write(da, int'($urandom_range(0, 3)), ea, (off == len_i - 1));
      end
    end

    // Full 2^AW buffer (length 0): wrap at offset 2^AW-1, then back to base
    do_reset();
    base_addr = 10'h3F0; buffer_length = 10'd0;
    for (int n = 0; n <= DEPTH; n++) begin
      off = n % DEPTH;
      ea  = AW'((int'(base_addr) + off) % DEPTH);
      do_write(32'(n) ^ 32'hA5A5_0000, 0, ea, (off == DEPTH - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_writer.md
SRAM_WRITER -- requirements
Module: sram_writer

Interface
REQ-001 Parameter AW, default 10, SRAM word-address width.
REQ-002 wb_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 wb_rst  input  1  reset, asynchronous, active-high.
REQ-004 sram_start  input  1  one-cycle pulse; sram_data_in is valid in the same cycle.
REQ-005 sram_data_in  input  32  sample word from the upstream FIFO-to-SRAM stage.
REQ-006 grant  input  1  arbiter grant of the SRAM port; level-sensitive.
REQ-007 base_addr  input  AW  first word address of the circular buffer; held static while busy.
REQ-008 buffer_length  input  AW  words in the buffer before wrap; 0 means 2^AW.
REQ-009 request  output  1  SRAM port request to arbiter.
REQ-010 sram_ce  output  1  SRAM chip enable.
REQ-011 sram_we  output  1  SRAM write enable.
REQ-012 sram_addr  output  AW  SRAM word address.
REQ-013 sram_wdata  output  32  SRAM write data.
REQ-014 data_done  output  1  one-cycle pulse after a word is written; returned to the upstream stage.
REQ-015 wrap  output  1  one-cycle pulse, coincident with the write of the last buffer word.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 overrun  output  1  sticky flag; cleared only by wb_rst.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WRITE and DONE, with all outputs decoded from state and registers only (Moore).
REQ-019 IDLE: on sram_start, capture sram_data_in into the hold register and go to REQ; otherwise remain in IDLE.
REQ-020 REQ: drive request=1; when grant=1 go to WRITE; otherwise remain in REQ indefinitely.
REQ-021 WRITE: drive request=1, sram_ce=1, sram_we=1, sram_wdata=hold, sram_addr=base_addr+offset (mod 2^AW), for exactly one cycle; then go to DONE.
REQ-022 The write SHALL complete if grant deasserts during WRITE.
REQ-023 DONE: drive data_done=1 and request=0 for one cycle; then go to IDLE.
REQ-024 Latency: with grant held high, a sram_start sampled at edge k gives WRITE in cycle k+1..k+2 and data_done in cycle k+2..k+3.
REQ-025 Offset update on leaving WRITE:
  - offset SHALL become 0 when offset == buffer_length-1, or when offset == 2^AW-1 for buffer_length=0;
  - otherwise offset SHALL increment by 1.
REQ-026 wrap SHALL be 1 during the WRITE cycle whose offset is the last buffer word.
REQ-027 sram_start while busy=1 SHALL be ignored (hold register unchanged) and SHALL set overrun=1.
REQ-028 sram_start in the DONE cycle SHALL also count as an overrun.
REQ-029 When not in WRITE, sram_ce, sram_we, sram_addr and sram_wdata SHALL be 0.

Reset
REQ-030 While wb_rst=1, the block SHALL force state=IDLE, offset=0, hold=0 and overrun=0, and drive every output to 0, asynchronously.
REQ-031 Reset asserted during REQ or WRITE SHALL abort the transfer with no data_done pulse.
REQ-032 After wb_rst deasserts, the next write SHALL go to base_addr+0.

Verification
REQ-033 Release reset -> request, sram_ce, sram_we, sram_addr, sram_wdata, data_done, wrap, busy and overrun all 0.
REQ-034 grant=1, base_addr=0x100, sram_start with data 0xDEADBEEF at edge k -> during cycle k+1 sram_we=1, sram_addr=0x100, sram_wdata=0xDEADBEEF; data_done=1 in cycle k+2 only.
REQ-035 grant=0 for 10 cycles after sram_start -> request stays 1 and sram_we stays 0; grant=1 -> write occurs one cycle later.
REQ-036 buffer_length=4, base_addr=0x10, 5 writes -> addresses 0x10, 0x11, 0x12, 0x13, 0x10; wrap pulses on the 0x13 write only.
REQ-037 Second sram_start while in REQ -> overrun=1, first data written, second data discarded; overrun stays 1 until reset.
REQ-038 wb_rst pulse during REQ -> request drops immediately, no data_done; next write goes to base_addr.
